stopwatch_ctrl: RTL

- Control FSM and timebase for the stopwatch counter chain (mm:ss.cc).
- Takes three debounced button levels (start/stop, lap, clear) and divides the system clock down to a 100 Hz tick.
- Drives the chain's count-enable and clear inputs, plus a display-hold strobe for lap (split) time.
- Sits between the top-level IO mapping and the counter chain / display latch.

---
 rtl/stopwatch_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, IDLE/RUN/STOP/LAP sequencing and
// the centisecond prescaler that paces the mm:ss.cc counter chain.
module stopwatch_ctrl #(
    parameter int CLK_DIV = 100000,
    parameter int DIV_W   = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       cnt_ena,
    output logic       cnt_res,
    output logic       disp_hold,
    output logic       running,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_t;

    localparam int NBTN    = 3;
    localparam int BTN_SS  = 0;
    localparam int BTN_LAP = 1;
    localparam int BTN_CLR = 2;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [NBTN-1:0] w_btn;
    logic [NBTN-1:0] w_ev;

    assign w_btn = {btn_clear, btn_lap, btn_start_stop};

    // Flops reset high so a button already held at reset release is not seen as a press.
    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic r_sync1;
            logic r_sync2;
            logic r_prev;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b1;
                    r_sync2 <= 1'b1;
                    r_prev  <= 1'b1;
                end else begin
                    r_sync1 <= w_btn[gi];
                    r_sync2 <= r_sync1;
                    r_prev  <= r_sync2;
                end
            end

            assign w_ev[gi] = r_sync2 & ~r_prev;
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_div;
    logic             r_cnt_ena;
    logic             r_cnt_res;
    logic             r_disp_hold;
    logic             r_running;

    logic w_run_now;
    logic w_run_next;
    logic w_div_wrap;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ev[BTN_SS]) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_ev[BTN_SS])       w_state_next = ST_STOP;
                else if (w_ev[BTN_LAP]) w_state_next = ST_LAP;
            end
            ST_LAP: begin
                if (w_ev[BTN_SS])       w_state_next = ST_STOP;
                else if (w_ev[BTN_LAP]) w_state_next = ST_RUN;
            end
            ST_STOP: begin
                if (w_ev[BTN_CLR])     w_state_next = ST_IDLE;
                else if (w_ev[BTN_SS]) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_run_now  = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_run_next = (w_state_next == ST_RUN) || (w_state_next == ST_LAP);
    assign w_div_wrap = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt_res   <= 1'b1;
            r_disp_hold <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt_res   <= (w_state_next == ST_IDLE);
            r_disp_hold <= (w_state_next == ST_LAP);
            r_running   <= w_run_next;
        end
    end

    // STOP holds the prescaler so a partial centisecond survives a pause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_cnt_ena <= 1'b0;
        end else begin
            if (w_state_next == ST_IDLE) begin
                r_div <= '0;
            end else if (w_run_now) begin
                r_div <= w_div_wrap ? '0 : r_div + DIV_W'(1);
            end
            r_cnt_ena <= w_run_now & w_run_next & w_div_wrap;
        end
    end

    assign cnt_ena   = r_cnt_ena;
    assign cnt_res   = r_cnt_res;
    assign disp_hold = r_disp_hold;
    assign running   = r_running;
    assign state     = r_state;

endmodule
